// File: rtl/ledmatrix_frame_scheduler.sv
// ---------------------------------------------------------------------------
// ledmatrix_frame_scheduler
//
// Double-buffered frame scheduler for an 8x8 LED matrix. Two requesters
// offer 64-bit frames through valid/ready handshakes. A round-robin arbiter
// moves one frame at a time into a back buffer. The back buffer is swapped
// onto the displayed frame (pixels) only on an end-of-scan load pulse, and
// only once the current frame has been shown for HOLD_FRAMES load pulses.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   req0_valid     requester 0 offers a frame
//   req0_frame     requester 0 frame, row r in bits [8r+7:8r]
//   req0_ready     requester 0 frame accepted this cycle (when valid)
//   req1_valid     requester 1 offers a frame
//   req1_frame     requester 1 frame
//   req1_ready     requester 1 frame accepted this cycle (when valid)
//   load           one-cycle end-of-scan pulse from the matrix driver
//   pixels         displayed frame (registered)
//   frame_pending  back buffer holds a frame that has not been shown yet
//   shown_id       requester index of the frame on pixels (registered)
//   frame_count    number of completed swaps, wraps at 16 bits (registered)
//
// States
//   EMPTY | back buffer free, arbiter may accept a frame
//   FULL  | back buffer holds a frame waiting for a qualifying load
// ---------------------------------------------------------------------------
module ledmatrix_frame_scheduler #(
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [63:0] req0_frame,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_frame,
  output logic        req1_ready,
  input  logic        load,
  output logic [63:0] pixels,
  output logic        frame_pending,
  output logic        shown_id,
  output logic [15:0] frame_count
);

  // Value loaded into the hold counter on a swap: the new frame must see
  // HOLD_FRAMES-1 further load pulses before the next swap is allowed.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_FRAMES - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        last_grant;
  logic [63:0] back_buf;
  logic        back_id;
  logic [7:0]  hold_cnt;

  logic        grant_valid;
  logic        grant_id;
  logic        xfer;
  logic        swap;

  // Round-robin arbitration: on a tie the port that did not win last time
  // is chosen. last_grant resets to 1 so port 0 wins the first tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and handshake outputs. Readies are gated by rst so
  // no requester sees its frame taken while reset is being applied.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    xfer       = 1'b0;
    swap       = 1'b0;
    case (state)
      EMPTY: begin
        if (!rst && grant_valid) begin
          xfer       = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_next = FULL;
        end
      end
      FULL: begin
        // A load that arrives while the hold counter is still running only
        // decrements it; the back buffer waits for a later load.
        if (load && (hold_cnt == 8'd0)) begin
          swap       = 1'b1;
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Back buffer and arbitration history
  always_ff @(posedge clk) begin
    if (rst) begin
      back_buf   <= 64'd0;
      back_id    <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      back_buf   <= grant_id ? req1_frame : req0_frame;
      back_id    <= grant_id;
      last_grant <= grant_id;
    end
  end

  // Displayed frame, hold counter and swap counter. A swap only happens in
  // FULL and a transfer only in EMPTY, so the two never share a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixels      <= 64'd0;
      shown_id    <= 1'b0;
      hold_cnt    <= 8'd0;
      frame_count <= 16'd0;
    end else if (swap) begin
      pixels      <= back_buf;
      shown_id    <= back_id;
      hold_cnt    <= HOLD_RELOAD;
      frame_count <= frame_count + 16'd1;
    end else if (load && (hold_cnt != 8'd0)) begin
      hold_cnt    <= hold_cnt - 8'd1;
    end
  end

  assign frame_pending = (state == FULL);

endmodule

// File: doc/ledmatrix_frame_scheduler.md
LEDMATRIX_FRAME_SCHEDULER -- requirements
Module: ledmatrix_frame_scheduler

Interface
REQ-001 Parameter HOLD_FRAMES, default 4, SHALL set the minimum number of matrix load pulses a displayed frame persists; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req0_valid  input  1  SHALL indicate requester 0 offers a frame.
REQ-005 req0_frame  input  64  SHALL carry requester 0 frame, row r in bits [8r+7:8r].
REQ-006 req0_ready  output  1  SHALL indicate requester 0 frame is accepted this cycle when req0_valid is high.
REQ-007 req1_valid, req1_frame, req1_ready  SHALL mirror REQ-004..006 for requester 1.
REQ-008 load  input  1  SHALL be the one-cycle end-of-scan pulse from the LED matrix driver.
REQ-009 pixels  output  64  SHALL drive the matrix driver pixel input; registered.
REQ-010 frame_pending  output  1  SHALL be high while the back buffer holds an undisplayed frame.
REQ-011 shown_id  output  1  SHALL give the requester index of the frame on pixels; registered.
REQ-012 frame_count  output  16  SHALL count completed swaps; registered.

Function
REQ-013 Block SHALL hold a 64-bit back buffer and a two-state FSM: EMPTY (back buffer free), FULL (back buffer awaiting swap).
REQ-014 Arbiter SHALL be round-robin over a last_grant register: one valid -> that port; both valid -> port != last_grant; none -> no grant.
REQ-015 reqN_ready SHALL be high only in EMPTY and only for the granted port; both readies never high together; combinational from valids and state.
REQ-016 Transfer SHALL occur when reqN_valid && reqN_ready: back buffer <= reqN_frame, back_id <= N, last_grant <= N, EMPTY -> FULL next cycle.
REQ-017 In FULL both readies SHALL be low; requesters hold valid and frame stable until accepted.
REQ-018 8-bit hold counter: on load with hold_cnt != 0, hold_cnt SHALL decrement by 1, in either state.
REQ-019 Swap SHALL occur on a cycle with state FULL, load high, hold_cnt == 0: pixels <= back buffer, shown_id <= back_id, hold_cnt <= HOLD_FRAMES-1, frame_count += 1, FULL -> EMPTY.
REQ-020 Swap latency: pixels SHALL change on the clock edge ending the qualifying load cycle; never outside a load cycle.
REQ-021 HOLD_FRAMES = 1 SHALL allow a swap on every load pulse.
REQ-022 Transfer and load in the same EMPTY cycle: transfer SHALL complete; no swap that cycle; swap occurs at the next qualifying load.
REQ-023 Load in FULL with hold_cnt != 0: SHALL only decrement hold_cnt; back buffer retained.
REQ-024 frame_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-025 frame_pending SHALL equal (state == FULL).
REQ-026 Without a new frame, pixels SHALL hold the last swapped frame indefinitely.

Reset
REQ-027 On rst: pixels = 0, shown_id = 0, frame_count = 0, hold_cnt = 0, state = EMPTY, last_grant = 1 (port 0 wins the first tie), back buffer = 0.
REQ-028 rst SHALL win over simultaneous transfer or load; a pending back-buffer frame is discarded.
REQ-029 During rst high, req0_ready and req1_ready SHALL be low.

Verification
REQ-030 Reset, req0 valid frame 0x0123456789ABCDEF, load after 3 cycles -> req0_ready high in cycle 1, frame_pending 1, pixels = 0x0123456789ABCDEF after that load edge, frame_count = 1, shown_id = 0.
REQ-031 Both valid from reset (A, B), HOLD_FRAMES=1, load every 64 cycles -> accepts A (port 0) then B (port 1), then alternates; shown_id sequence 0,1,0,1.
REQ-032 HOLD_FRAMES=4, frame X shown, frame Y accepted immediately -> Y appears only on the 4th load after X's swap; loads 1..3 leave pixels = X, frame_pending 1.
REQ-033 Transfer in EMPTY on the same cycle as load, hold_cnt 0 -> no swap that edge; swap on the next load.
REQ-034 rst asserted while FULL -> next cycle pixels = 0, frame_pending 0, frame_count 0; subsequent load causes no swap.
REQ-035 Force 65536 swaps (HOLD_FRAMES=1) -> frame_count returns to 0x0000; pixels still track accepted frames.
